// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between pipe_ctrl and the pipeline stages: stall requests,
// exception/branch events in; stall, flush and redirect controls plus counters out.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic              stallreq_if;
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              stallreq_mem;
  logic              exc_valid;
  logic              exc_is_eret;
  logic [31:0]       epc_i;
  logic              bp_fail;
  logic [31:0]       bp_target;
  logic [3:0]        stall;
  logic              stall_if;
  logic              flush;
  logic              flush_cause;
  logic [31:0]       new_pc;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output exc_valid, exc_is_eret, epc_i, bp_fail, bp_target,
    input  stall, stall_if, flush, flush_cause, new_pc, stall_cycles, flush_count
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  exc_valid, exc_is_eret, epc_i, bp_fail, bp_target,
    output stall, stall_if, flush, flush_cause, new_pc, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, arbitrates exception vs. branch flushes,
// parks a branch redirect that arrives under a memory stall until the stall clears.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned CNT_W      = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StBrPend, StExcDrain} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [31:0]      r_pend_target;
  logic             w_pend_load;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic [3:0]  w_merge;
  logic [3:0]  w_stall;
  logic        w_stall_if;
  logic        w_flush;
  logic        w_cause;
  logic [31:0] w_new_pc;

  always_comb begin
    if (bus.stallreq_mem)      w_merge = 4'b0111;
    else if (bus.stallreq_ex)  w_merge = 4'b0011;
    else if (bus.stallreq_id)  w_merge = 4'b0001;
    else                       w_merge = 4'b0000;
  end

  always_comb begin
    w_stall      = w_merge;
    w_stall_if   = bus.stallreq_if | w_merge[0];
    w_flush      = 1'b0;
    w_cause      = 1'b0;
    w_new_pc     = 32'h0;
    w_state_next = r_state;
    w_pend_load  = 1'b0;
    unique case (r_state)
      StRun: begin
        if (bus.exc_valid) begin
          w_stall      = 4'b0000;
          w_stall_if   = 1'b0;
          w_flush      = 1'b1;
          w_cause      = 1'b1;
          w_new_pc     = bus.exc_is_eret ? bus.epc_i : EXC_VECTOR;
          w_state_next = StExcDrain;
        end else if (bus.bp_fail && !bus.stallreq_mem) begin
          // ID/EX keeps the delay slot when EX is busy, so the merged stall stays.
          w_stall_if = bus.stallreq_if;
          w_flush    = 1'b1;
          w_new_pc   = bus.bp_target;
        end else if (bus.bp_fail) begin
          w_pend_load  = 1'b1;
          w_state_next = StBrPend;
        end
      end
      StBrPend: begin
        if (bus.exc_valid) begin
          w_stall      = 4'b0000;
          w_stall_if   = 1'b0;
          w_flush      = 1'b1;
          w_cause      = 1'b1;
          w_new_pc     = bus.exc_is_eret ? bus.epc_i : EXC_VECTOR;
          w_state_next = StExcDrain;
        end else if (!bus.stallreq_mem) begin
          w_flush      = 1'b1;
          w_new_pc     = r_pend_target;
          w_state_next = StRun;
        end
      end
      StExcDrain: begin
        w_stall      = 4'b0000;
        w_stall_if   = bus.stallreq_if;
        w_state_next = StRun;
      end
      default: w_state_next = StRun;
    endcase
    if (rst) begin
      w_stall    = 4'b0000;
      w_stall_if = 1'b0;
      w_flush    = 1'b0;
      w_cause    = 1'b0;
      w_new_pc   = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StRun;
      r_pend_target  <= 32'h0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pend_load) r_pend_target <= bus.bp_target;
      if ((w_stall != 4'b0000) || w_stall_if) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_flush) r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign bus.stall        = w_stall;
  assign bus.stall_if     = w_stall_if;
  assign bus.flush        = w_flush;
  assign bus.flush_cause  = w_cause;
  assign bus.new_pc       = w_new_pc;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the dual-issue core. It merges per-stage stall requests into the shared `stall[3:0]` vector and the fetch stall. It arbitrates between exception flushes and branch-misprediction flushes, and drives the redirect PC. A branch misprediction that arrives during a memory-stage stall is parked in a pending register and released when the stall clears. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers, which consume `stall`, `flush` and `flush_cause`.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry address.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stallreq_if  in  1  instruction-fetch miss
- stallreq_id  in  1  load-use / issue hazard
- stallreq_ex  in  1  multi-cycle EX op (div/mul)
- stallreq_mem  in  1  data-cache miss / uncached access
- exc_valid  in  1  committed exception or ERET from the MEM stage
- exc_is_eret  in  1  qualifies exc_valid as ERET
- epc_i  in  32  CP0 EPC value
- bp_fail  in  1  EX-stage branch misprediction detected
- bp_target  in  32  correct branch target
- stall  out  4  bit0 ID, bit1 EX, bit2 MEM, bit3 WB; 1 = stop
- stall_if  out  1  hold PC and IF/ID
- flush  out  1  flush strobe
- flush_cause  out  1  `Exception` (1) or `FailedBranchPrediction` (0)
- new_pc  out  32  redirect address, valid when flush=1
- stall_cycles  out  CNT_W  count of cycles with any stall bit set
- flush_count  out  CNT_W  count of flush strobes

## Operation
- States: RUN, BR_PEND, EXC_DRAIN. Registers: state, pend_target[31:0], both counters.
- The stall vector is built from requests by highest-stage priority:
  - stallreq_mem gives 4'b0111.
  - else stallreq_ex gives 4'b0011.
  - else stallreq_id gives 4'b0001.
  - else 4'b0000.
- stall_if = stallreq_if | stall[0], except where an override below applies.
- RUN:
  - exc_valid: flush=1, cause=Exception, new_pc = exc_is_eret ? epc_i : EXC_VECTOR, stall=0000, stall_if=0. Next state EXC_DRAIN.
  - else bp_fail & !stallreq_mem: flush=1, cause=FailedBranchPrediction, new_pc=bp_target. Stall vector from requests; with stallreq_ex, stall=0011 and ID/EX holds the delay slot. stall_if=stallreq_if. Stay in RUN.
  - else bp_fail & stallreq_mem: flush=0, stall=0111, stall_if=1, pend_target<=bp_target. Next state BR_PEND.
  - else: normal stall merge, flush=0, new_pc=0.
- BR_PEND:
  - bp_fail is ignored; it is the same branch held in EX.
  - exc_valid: exception flush exactly as in RUN; the pending target is discarded. Next state EXC_DRAIN.
  - else stallreq_mem: stall=0111, stall_if=1, flush=0.
  - else: flush=1, cause=FailedBranchPrediction, new_pc=pend_target, stall merged from remaining requests. Next state RUN.
- EXC_DRAIN: lasts one cycle. exc_valid, bp_fail, stallreq_id and stallreq_ex are ignored. stall=0000, stall_if=stallreq_if, flush=0. Next state RUN.
- Counters:
  - stall_cycles increments when stall!=0 or stall_if=1.
  - flush_count increments on every flush=1 cycle.
  - Both wrap modulo 2^CNT_W.

## Timing
- stall, stall_if, flush, flush_cause and new_pc are combinational from the inputs and the current state. Pipeline registers sample them at the same clk edge, so there is zero-cycle latency from request to stall.
- State, pend_target and the counters update on posedge clk.
- Reset:
  - While rst=1, all outputs are forced 0: stall=0000, stall_if=0, flush=0, flush_cause=0, new_pc=0.
  - On the clock edge: state<=RUN, pend_target<=0, counters<=0.
  - rst asserted in BR_PEND drops the pending redirect.
- flush is a single-cycle strobe per event. Back-to-back exceptions are separated by at least one EXC_DRAIN cycle.
- Simultaneous exc_valid and bp_fail: the exception wins and no branch flush is emitted.
- A branch flush with stallreq_ex=1 asserts flush together with stall=0011 in the same cycle.

## Test plan
- Reset: hold rst for 2 cycles with all requests high -> all outputs 0; counters read 0 after release.
- Stall priority: stallreq_id=1 -> stall=0001, stall_if=1. Add stallreq_ex -> 0011. Add stallreq_mem -> 0111. Drop all -> 0000. stall_cycles = 3.
- Branch flush: bp_fail=1, bp_target=32'h8000_1040, no stalls -> one cycle flush=1, cause=0, new_pc=32'h8000_1040, stall=0000. With stallreq_ex=1 -> flush=1 and stall=0011.
- Deferred branch: bp_fail=1 with stallreq_mem=1 for 3 cycles, bp_target=32'h8000_2000 -> flush=0 and stall=0111 for 3 cycles. Drop stallreq_mem -> flush=1, new_pc=32'h8000_2000, state RUN.
- Exception preempts pending branch: in BR_PEND assert exc_valid, exc_is_eret=0 -> flush=1, cause=1, new_pc=32'hBFC00380, stall=0000. Next cycle flush=0 even with bp_fail=1.
- ERET and simultaneous events: exc_valid=1, exc_is_eret=1, epc_i=32'h8000_0100, bp_fail=1 -> new_pc=32'h8000_0100, cause=Exception, flush_count increments by 1.
